// File: rtl/fsm_run_detector.sv
// fsm_run_detector: detects runs of RUN_LEN consecutive ones on a serial input.
// Ports: clk, reset (sync, active-high); enable gates sampling; data_in serial bit;
// overlap selects overlapping detection; clear_cnt zeroes the detection counter;
// detect_moore (registered), detect_mealy (combinational), run_count (live run
// length), det_count (saturating detections), det_sat (counter at maximum).
module fsm_run_detector #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         data_in,
    input  logic                         overlap,
    input  logic                         clear_cnt,
    output logic                         detect_moore,
    output logic                         detect_mealy,
    output logic [$clog2(RUN_LEN+1)-1:0] run_count,
    output logic [CNT_W-1:0]             det_count,
    output logic                         det_sat
);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] LAST = RW'(RUN_LEN);
    localparam logic [RW-1:0] PRE  = RW'(RUN_LEN - 1);

    logic [RW-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             moore_q, sat_q;

    // In DETECT a further one either holds the state (overlap) or restarts the run at 1.
    always_comb begin
        ones_d  = !enable ? ones_q : !data_in ? '0 : ones_q != LAST ? ones_q + 1'b1 :
                  overlap ? LAST : RW'(1);
        cnt_inc = cnt_q + CNT_W'(1);
    end

    assign detect_mealy = enable & data_in & !reset &
                          (ones_q == PRE | (overlap & ones_q == LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            ones_q  <= '0;
            moore_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            moore_q <= ones_d == LAST;
            // Clear wins over a detection in the same cycle.
            if (clear_cnt) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (detect_mealy && !sat_q) begin
                cnt_q <= cnt_inc;
                sat_q <= &cnt_inc;
            end
        end
    end

    assign detect_moore = moore_q;
    assign run_count    = ones_q;
    assign det_count    = cnt_q;
    assign det_sat      = sat_q;
endmodule

// File: tb/tb_fsm_run_detector.sv
// tb_fsm_run_detector: directed and random checks of fsm_run_detector against a run-length model.
module tb_fsm_run_detector;
    localparam int L    = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, data_in = 1'b0, overlap = 1'b0, clear_cnt = 1'b0;
    logic detect_moore, detect_mealy, det_sat;
    logic [1:0] run_count;
    logic [CW-1:0] det_count;

    int passes = 0, checks = 0;
    int run_m = 0, cnt_m = 0, max_run = 0, mealy_hits = 0;

    always #5 clk = ~clk;

    fsm_run_detector #(.RUN_LEN(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
        .overlap(overlap), .clear_cnt(clear_cnt), .detect_moore(detect_moore),
        .detect_mealy(detect_mealy), .run_count(run_count),
        .det_count(det_count), .det_sat(det_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Model: run_m is the unbounded count of consecutive sampled ones since the last
    // zero, reset, or non-overlap restart; the visible state is min(run_m, L).
    task automatic step(input logic r, input logic e, input logic d, input logic o, input logic c);
        logic em;
        @(negedge clk);
        reset = r; enable = e; data_in = d; overlap = o; clear_cnt = c;
        em = e & d & !r & (run_m >= L - 1) & ((run_m < L) | o);
        #1 chk("mealy", detect_mealy, em);
        if (detect_mealy) mealy_hits++;
        @(posedge clk);
        if (r) begin
            run_m = 0;
            cnt_m = 0;
        end else begin
            if (e) run_m = !d ? 0 : (run_m >= L && !o) ? 1 : run_m + 1;
            if (c) cnt_m = 0;
            else if (em && cnt_m < CMAX) cnt_m++;
        end
        #1;
        chk("moore", detect_moore, run_m >= L);
        chk("run_count", run_count, run_m < L ? run_m : L);
        chk("det_count", det_count, cnt_m);
        chk("det_sat", det_sat, cnt_m == CMAX);
        if (run_count > max_run) max_run = run_count;
    endtask

    task automatic bit_(input logic d, input logic o);
        step(1'b0, 1'b1, d, o, 1'b0);
    endtask

    task automatic rst2();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mealy_hits = 0;
        max_run = 0;
    endtask

    task automatic seq(input string s, input logic o);
        for (int i = 0; i < s.len(); i++) bit_(s[i] == "1", o);
    endtask

    initial begin
        rst2();
        chk("rst_moore", detect_moore, 0);
        chk("rst_count", det_count, 0);
        chk("rst_run", run_count, 0);

        seq("1110", 1'b0);
        chk("tp1_cnt", det_count, 1);
        chk("tp1_hits", mealy_hits, 1);

        rst2();
        seq("1111110", 1'b0);
        chk("nov_cnt", det_count, 2);

        rst2();
        seq("1111110", 1'b1);
        chk("ov_cnt", det_count, 4);
        chk("ov_hits", mealy_hits, 4);

        rst2();
        seq("1101110110", 1'b0);
        chk("mix_cnt", det_count, 1);

        rst2();
        seq("10101010", 1'b0);
        chk("alt_cnt", det_count, 0);
        chk("alt_maxrun", max_run, 1);

        rst2();
        seq("110", 1'b0);
        chk("short_cnt", det_count, 0);

        rst2();
        seq("11", 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_(1'b1, 1'b0);
        chk("gap_hits", mealy_hits, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_moore_hold", detect_moore, 1);

        rst2();
        for (int i = 0; i < 20; i++) bit_(1'b1, 1'b1);
        chk("sat_hits", mealy_hits, 18);
        chk("sat_cnt", det_count, 15);
        chk("sat_flag", det_sat, 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_cnt", det_count, 0);
        chk("clr_sat", det_sat, 0);
        chk("clr_run", run_count, 3);
        bit_(1'b1, 1'b1);
        chk("clr_next", det_count, 1);

        rst2();
        seq("11", 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_run", run_count, 0);
        seq("11", 1'b0);
        chk("midrst_none", det_count, 0);
        bit_(1'b1, 1'b0);
        chk("midrst_det", det_count, 1);

        rst2();
        for (int i = 0; i < 2000; i++)
            step($urandom_range(99) < 2, $urandom_range(9) < 8, $urandom_range(9) < 7,
                 $urandom_range(9) < 4, $urandom_range(99) < 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
